// File: rtl/axis_arbiter.sv
// Round-robin AXI4-Stream arbiter: merges N_PORTS slave streams onto one master,
// holding ownership for a whole packet (until the tlast beat transfers).
module axis_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 16
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [N_PORTS*DATA_WIDTH-1:0]     s_tdata,
  input  logic [N_PORTS*(DATA_WIDTH/8)-1:0] s_tstrb,
  input  logic [N_PORTS*(DATA_WIDTH/8)-1:0] s_tkeep,
  input  logic [N_PORTS*ID_WIDTH-1:0]       s_tid,
  input  logic [N_PORTS*DEST_WIDTH-1:0]     s_tdest,
  input  logic [N_PORTS*USER_WIDTH-1:0]     s_tuser,
  input  logic [N_PORTS-1:0]                s_tlast,
  input  logic [N_PORTS-1:0]                s_tvalid,
  output logic [N_PORTS-1:0]                s_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_tstrb,
  output logic [DATA_WIDTH/8-1:0]           m_tkeep,
  output logic [ID_WIDTH-1:0]               m_tid,
  output logic [DEST_WIDTH-1:0]             m_tdest,
  output logic [USER_WIDTH-1:0]             m_tuser,
  output logic                              m_tlast,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [$clog2(N_PORTS)-1:0]        grant,
  output logic                              grant_valid
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int GW = $clog2(N_PORTS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_next;
  logic [GW-1:0] grant_q, grant_next;
  logic [GW-1:0] last_q, last_next;
  logic [GW-1:0] winner, cand;
  logic          sel_valid, sel_last, locked, xfer;

  // Walk candidates from farthest to nearest so the nearest valid port after
  // last_q is the final assignment.
  always_comb begin
    winner = grant_q;
    cand   = '0;
    for (int unsigned i = N_PORTS; i > 0; i--) begin
      cand = GW'((32'(last_q) + i) % N_PORTS);
      if (s_tvalid[cand]) winner = cand;
    end
  end

  always_comb begin
    m_tdata   = '0;
    m_tstrb   = '0;
    m_tkeep   = '0;
    m_tid     = '0;
    m_tdest   = '0;
    m_tuser   = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (grant_q == GW'(p)) begin
        m_tdata   = s_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        m_tstrb   = s_tstrb[p*KW +: KW];
        m_tkeep   = s_tkeep[p*KW +: KW];
        m_tid     = s_tid[p*ID_WIDTH +: ID_WIDTH];
        m_tdest   = s_tdest[p*DEST_WIDTH +: DEST_WIDTH];
        m_tuser   = s_tuser[p*USER_WIDTH +: USER_WIDTH];
        sel_last  = s_tlast[p];
        sel_valid = s_tvalid[p];
      end
    end
  end

  // Handshake outputs are gated by areset so they read idle for the whole reset
  // cycle, including the one where the state register still says LOCKED.
  assign locked      = (state == LOCKED) && !areset;
  assign xfer        = locked && sel_valid && m_tready;
  assign m_tlast     = sel_last;
  assign m_tvalid    = locked && sel_valid;
  assign grant_valid = locked;
  assign grant       = areset ? '0 : grant_q;

  always_comb begin
    s_tready = '0;
    if (locked) s_tready[grant_q] = m_tready;
  end

  always_comb begin
    state_next = state;
    grant_next = grant_q;
    last_next  = last_q;
    case (state)
      IDLE: begin
        if (|s_tvalid) begin
          grant_next = winner;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer && sel_last) begin
          last_next  = grant_q;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_PORTS - 1);
    end else begin
      state   <= state_next;
      grant_q <= grant_next;
      last_q  <= last_next;
    end
  end

endmodule

// File: tb/tb_axis_arbiter.sv
// Randomized scoreboard bench for axis_arbiter: a packet-level reference model
// predicts each cycle's handshake and payload; a monitor compares on negedge.
module tb_axis_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int KW  = DW / 8;
  localparam int IW  = 4;
  localparam int DSW = 4;
  localparam int UW  = 16;
  localparam int GW  = $clog2(N);
  localparam int NCYC = 4000;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [N*DW-1:0]   s_tdata = '0;
  logic [N*KW-1:0]   s_tstrb = '0;
  logic [N*KW-1:0]   s_tkeep = '0;
  logic [N*IW-1:0]   s_tid = '0;
  logic [N*DSW-1:0]  s_tdest = '0;
  logic [N*UW-1:0]   s_tuser = '0;
  logic [N-1:0]      s_tlast = '0;
  logic [N-1:0]      s_tvalid = '0;
  logic [N-1:0]      s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tstrb;
  logic [KW-1:0]     m_tkeep;
  logic [IW-1:0]     m_tid;
  logic [DSW-1:0]    m_tdest;
  logic [UW-1:0]     m_tuser;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic [GW-1:0]     grant;
  logic              grant_valid;

  axis_arbiter #(
    .N_PORTS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tid(s_tid),
    .s_tdest(s_tdest), .s_tuser(s_tuser), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tid(m_tid),
    .m_tdest(m_tdest), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .grant(grant), .grant_valid(grant_valid)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [KW-1:0]  strb;
    logic [KW-1:0]  keep;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
    logic           last;
  } beat_t;

  typedef struct {
    logic          gv;
    logic [GW-1:0] grant;
    logic [N-1:0]  ready;
    logic          mvalid;
    logic          xfer;
    beat_t         beat;
  } exp_t;

  beat_t src_q [N][$];
  exp_t  exp_q [$];
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, expv);
    end
  endtask

  function automatic void new_packet(input int p);
    int unsigned len = $urandom_range(1, 4);
    beat_t b;
    for (int unsigned k = 0; k < len; k++) begin
      b.data = $urandom;
      b.strb = KW'($urandom);
      b.keep = KW'($urandom);
      b.id   = IW'(p);
      b.dest = DSW'($urandom);
      b.user = UW'($urandom);
      b.last = (k == len - 1);
      src_q[p].push_back(b);
    end
  endfunction

  // Monitor: one expected record per cycle, compared away from the clock edge.
  initial begin
    exp_t e;
    beat_t act;
    forever begin
      @(negedge aclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant_valid", 128'(grant_valid), 128'(e.gv));
        check("grant", 128'(grant), 128'(e.grant));
        check("s_tready", 128'(s_tready), 128'(e.ready));
        check("m_tvalid", 128'(m_tvalid), 128'(e.mvalid));
        if (e.xfer) begin
          act = {m_tdata, m_tstrb, m_tkeep, m_tid, m_tdest, m_tuser, m_tlast};
          check("payload", 128'(act), 128'(e.beat));
        end
      end
    end
  end

  // Stimulus plus reference model: owner < 0 means no port holds the stream.
  initial begin
    int owner = -1;
    int last_g = N - 1;
    int grant_m = 0;
    logic [N-1:0] vflag;
    bit rst_now;
    beat_t b;
    exp_t e;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge aclk);
      #1;
      rst_now = (c < 3) || ($urandom_range(0, 299) == 0);
      areset  = rst_now;
      vflag   = '0;
      for (int p = 0; p < N; p++) begin
        if (src_q[p].size() == 0 && $urandom_range(0, 3) != 0) new_packet(p);
        if (src_q[p].size() > 0) begin
          b = src_q[p][0];
          vflag[p] = ($urandom_range(0, 9) != 0);
        end else begin
          b = {$urandom, $urandom, $urandom};
        end
        s_tdata[p*DW +: DW]   = b.data;
        s_tstrb[p*KW +: KW]   = b.strb;
        s_tkeep[p*KW +: KW]   = b.keep;
        s_tid[p*IW +: IW]     = b.id;
        s_tdest[p*DSW +: DSW] = b.dest;
        s_tuser[p*UW +: UW]   = b.user;
        s_tlast[p]            = b.last;
      end
      s_tvalid = vflag;
      m_tready = ($urandom_range(0, 3) != 0);

      e.beat = '0;
      e.xfer = 1'b0;
      e.ready = '0;
      e.mvalid = 1'b0;
      if (rst_now) begin
        e.gv = 1'b0;
        e.grant = '0;
        owner = -1;
        last_g = N - 1;
        grant_m = 0;
        for (int p = 0; p < N; p++) src_q[p].delete();
      end else if (owner < 0) begin
        e.gv = 1'b0;
        e.grant = GW'(grant_m);
        for (int k = N; k >= 1; k--)
          if (vflag[(last_g + k) % N]) owner = (last_g + k) % N;
        if (owner >= 0) grant_m = owner;
      end else begin
        e.gv = 1'b1;
        e.grant = GW'(grant_m);
        e.ready = m_tready ? (N'(1) << owner) : '0;
        e.mvalid = vflag[owner];
        e.xfer = vflag[owner] && m_tready;
        if (e.xfer) begin
          e.beat = src_q[owner].pop_front();
          if (e.beat.last) begin
            last_g = owner;
            owner = -1;
          end
        end
      end
      exp_q.push_back(e);
    end
    @(negedge aclk);
    #1;
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
